univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 88 ++++++++
 tb/tb_univ_shift_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: shift/rotate both ways, parallel load, clear, with a frame counter.
// Latency: one clk from the operation edge to PR/cnt/frame_done; SR_out/SL_out are taps of PR.
// Backpressure: none; enable=0 freezes PR and cnt and drops frame_done on the next edge.
module univ_shift_reg #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [2:0]    mode,
  input  logic          SR_in,
  input  logic          SL_in,
  input  logic [N-1:0]  PL_in,
  output logic [N-1:0]  PR,
  output logic          SR_out,
  output logic          SL_out,
  output logic [CW-1:0] cnt,
  output logic          frame_done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  // Last count value of a frame; the shift that lands here completes the frame.
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          is_shift;
  logic [N-1:0]  shift_val;

  // Compute the shifted/rotated value and flag whether this mode counts toward the frame.
  always_comb begin
    is_shift  = 1'b0;
    shift_val = PR;
    case (mode)
      M_SHR: begin is_shift = 1'b1; shift_val = {SR_in, PR[N-1:1]}; end
      M_SHL: begin is_shift = 1'b1; shift_val = {PR[N-2:0], SL_in}; end
      M_ROR: begin is_shift = 1'b1; shift_val = {PR[0], PR[N-1:1]}; end
      M_ROL: begin is_shift = 1'b1; shift_val = {PR[N-2:0], PR[N-1]}; end
      default: begin is_shift = 1'b0; shift_val = PR; end
    endcase
  end

  // Register, frame counter and frame-complete pulse; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PR         <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      // Pulse is one cycle wide: default low, raised only by a frame-completing shift.
      frame_done <= 1'b0;
      if (enable) begin
        if (is_shift) begin
          PR <= shift_val;
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (mode == M_LOAD) begin
          // A load abandons any partial frame.
          PR  <= PL_in;
          cnt <= '0;
        end else if (mode == M_CLR) begin
          PR  <= '0;
          cnt <= '0;
        end
        // M_HOLD and the reserved code fall through: PR and cnt keep their values.
      end
    end
  end

  // Serial taps follow PR directly.
  assign SR_out = PR[0];
  assign SL_out = PR[N-1];

  // M_HOLD is named for readability of the mode map; it needs no explicit branch.
  logic unused_hold;
  assign unused_hold = (mode == M_HOLD);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] mode;
  logic       SR_in;
  logic       SL_in;
  logic [7:0] PL_in;
  logic [7:0] PR;
  logic       SR_out;
  logic       SL_out;
  logic [2:0] cnt;
  logic       frame_done;

  univ_shift_reg #(.N(8), .CW(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .SR_in(SR_in), .SL_in(SL_in), .PL_in(PL_in),
    .PR(PR), .SR_out(SR_out), .SL_out(SL_out),
    .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pr;
    logic [2:0] cnt;
    logic       fd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_pr;
  logic [2:0] m_cnt;
  int         n_pass  = 0;
  int         n_total = 0;
  int         fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one operation at the falling edge, predict its result, compare after the rising edge.
  task automatic step(input logic en, input logic [2:0] md, input logic sr, input logic sl,
                      input logic [7:0] pl);
    exp_t e;
    logic fd;
    @(negedge clk);
    enable = en; mode = md; SR_in = sr; SL_in = sl; PL_in = pl;
    fd = 1'b0;
    if (en) begin
      case (md)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          case (md)
            3'd1:    m_pr = {sr, m_pr[7:1]};
            3'd2:    m_pr = {m_pr[6:0], sl};
            3'd3:    m_pr = {m_pr[0], m_pr[7:1]};
            default: m_pr = {m_pr[6:0], m_pr[7]};
          endcase
          if (m_cnt == 3'd7) begin m_cnt = 3'd0; fd = 1'b1; end
          else m_cnt = m_cnt + 3'd1;
        end
        3'd5: begin m_pr = pl;    m_cnt = 3'd0; end
        3'd6: begin m_pr = 8'h00; m_cnt = 3'd0; end
        default: ;
      endcase
    end
    sb.push_back('{pr: m_pr, cnt: m_cnt, fd: fd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pr",     32'(PR),         32'(e.pr));
    chk("cnt",    32'(cnt),        32'(e.cnt));
    chk("fd",     32'(frame_done), 32'(e.fd));
    chk("sr_out", 32'(SR_out),     32'(e.pr[0]));
    chk("sl_out", 32'(SL_out),     32'(e.pr[7]));
    if (frame_done) fd_seen++;
  endtask

  initial begin
    logic [7:0] sr_seq;
    rst = 1'b1; enable = 1'b0; mode = 3'd0; SR_in = 1'b0; SL_in = 1'b0; PL_in = 8'h00;
    m_pr = 8'h00; m_cnt = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pr",  32'(PR),         32'h0);
    chk("rst_cnt", 32'(cnt),        32'h0);
    chk("rst_fd",  32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-frame: build PR=5A, cnt=3 via load 4B and three rotate-lefts.
    step(1, 3'd5, 0, 0, 8'h4B);
    repeat (3) step(1, 3'd4, 0, 0, 8'h00);
    chk("pre_rst_pr",  32'(PR),  32'h5A);
    chk("pre_rst_cnt", 32'(cnt), 32'h3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_pr",  32'(PR),         32'h0);
    chk("async_cnt", 32'(cnt),        32'h0);
    chk("async_fd",  32'(frame_done), 32'h0);
    // Inputs must be ignored while reset is held.
    @(negedge clk);
    enable = 1'b1; mode = 3'd5; PL_in = 8'hFF;
    @(posedge clk);
    #1;
    chk("rst_ignore_pr", 32'(PR), 32'h0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; mode = 3'd0;
    m_pr = 8'h00; m_cnt = 3'd0;

    // Serial out: load A5, eight right shifts with SR_in=1.
    sr_seq = 8'b10100101;
    step(1, 3'd5, 0, 0, 8'hA5);
    fd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sr_seq", 32'(SR_out), 32'(sr_seq[7-i]));
      step(1, 3'd1, 1, 0, 8'h00);
    end
    chk("sr_final_pr",  32'(PR),         32'hFF);
    chk("sr_final_cnt", 32'(cnt),        32'h0);
    chk("sr_final_fd",  32'(frame_done), 32'h1);
    chk("sr_fd_count",  32'(fd_seen),    32'h1);
    step(1, 3'd0, 0, 0, 8'h00);

    // Rotate left: 81 -> 03, then seven more back to 81 with a single pulse.
    step(1, 3'd5, 0, 0, 8'h81);
    fd_seen = 0;
    step(1, 3'd4, 0, 0, 8'h00);
    chk("rol1_pr", 32'(PR), 32'h03);
    repeat (7) step(1, 3'd4, 0, 0, 8'h00);
    chk("rol8_pr",   32'(PR),      32'h81);
    chk("rol_fd_ct", 32'(fd_seen), 32'h1);
    // A pending pulse is dropped by a disabled cycle.
    step(0, 3'd1, 0, 0, 8'h00);

    // Hold / enable: PR=3C, cnt=2 via load 0F and two rotate-lefts.
    step(1, 3'd5, 0, 0, 8'h0F);
    repeat (2) step(1, 3'd4, 0, 0, 8'h00);
    repeat (4) step(0, 3'd1, 1, 1, 8'hFF);
    chk("en0_pr",  32'(PR),         32'h3C);
    chk("en0_cnt", 32'(cnt),        32'h2);
    chk("en0_fd",  32'(frame_done), 32'h0);
    repeat (4) step(1, 3'd7, 1, 1, 8'hFF);
    chk("m7_pr",  32'(PR),  32'h3C);
    chk("m7_cnt", 32'(cnt), 32'h2);

    // Mid-frame load discards the partial frame; mixed directions all count.
    step(1, 3'd6, 0, 0, 8'h00);
    fd_seen = 0;
    for (int i = 0; i < 5; i++) step(1, 3'(1 + (i % 4)), i[0], ~i[0], 8'h00);
    step(1, 3'd5, 0, 0, 8'h0F);
    chk("ld_cnt", 32'(cnt),        32'h0);
    chk("ld_fd",  32'(frame_done), 32'h0);
    for (int i = 0; i < 7; i++) step(1, 3'(1 + (i % 4)), ~i[0], i[0], 8'h00);
    chk("mix7_fd_ct", 32'(fd_seen), 32'h0);
    step(1, 3'd2, 0, 1, 8'h00);
    chk("mix8_fd",    32'(frame_done), 32'h1);
    chk("mix8_fd_ct", 32'(fd_seen),    32'h1);

    // Left shift from clear with SL_in=1.
    step(1, 3'd6, 0, 0, 8'h00);
    fd_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 3'd2, 0, 1, 8'h00);
      chk("sl_out_low", 32'(SL_out), 32'h0);
    end
    step(1, 3'd2, 0, 1, 8'h00);
    chk("sl_final_pr", 32'(PR),      32'hFF);
    chk("sl_fd_ct",    32'(fd_seen), 32'h1);
    step(1, 3'd0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
